// File: rtl/sdram_avalon_master.sv
// Single-outstanding Avalon-MM master for the SDRAM controller s1 slave.
// It turns the core's level read/write requests into one Avalon transfer at a
// time. It returns read data with a one-cycle sdram_finished pulse.
// A read whose readdatavalid never arrives is ended by a timeout guard, which
// also sets a sticky flag. Every output comes straight from a flop.
module sdram_avalon_master #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              sdram_read,
  input  logic              sdram_write,
  input  logic [ADDR_W-1:0] sdram_addr,
  input  logic [DATA_W-1:0] sdram_writedata,
  output logic [DATA_W-1:0] sdram_readdata,
  output logic              sdram_finished,
  output logic              o_busy,
  output logic              o_timeout,
  output logic [2:0]        o_state,
  output logic [ADDR_W-1:0] new_sdram_controller_0_s1_address,
  output logic [3:0]        new_sdram_controller_0_s1_byteenable_n,
  output logic              new_sdram_controller_0_s1_chipselect,
  output logic [DATA_W-1:0] new_sdram_controller_0_s1_writedata,
  output logic              new_sdram_controller_0_s1_read_n,
  output logic              new_sdram_controller_0_s1_write_n,
  input  logic [DATA_W-1:0] new_sdram_controller_0_s1_readdata,
  input  logic              new_sdram_controller_0_s1_readdatavalid,
  input  logic              new_sdram_controller_0_s1_waitrequest
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Short local names for the slave-side inputs.
  logic              s1_waitrequest;
  logic              s1_readdatavalid;
  logic [DATA_W-1:0] s1_readdata;
  assign s1_waitrequest   = new_sdram_controller_0_s1_waitrequest;
  assign s1_readdatavalid = new_sdram_controller_0_s1_readdatavalid;
  assign s1_readdata      = new_sdram_controller_0_s1_readdata;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              finished_q, finished_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              read_n_q, read_n_d;
  logic              write_n_q, write_n_d;
  logic              cs_q, cs_d;
  logic [3:0]        be_n_q, be_n_d;

  // Next-state and next-output logic. Strobes are computed from the next state,
  // so they leave flops and appear in the same cycle as the state they belong to.
  always_comb begin
    // NOTE: every signal gets a default before the case. Otherwise a path that
    // does not assign it would infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    finished_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Read has priority. A write that arrives together with a read is dropped.
        if (sdram_read) begin
          addr_d  = sdram_addr;
          state_d = ST_RD_REQ;
        end else if (sdram_write) begin
          addr_d  = sdram_addr;
          wdata_d = sdram_writedata;
          state_d = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!s1_waitrequest) begin
          if (s1_readdatavalid) begin
            // A zero-latency slave returns data in the same cycle it accepts the read.
            rdata_d    = s1_readdata;
            finished_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            cnt_d   = '0;
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (s1_readdatavalid) begin
          rdata_d    = s1_readdata;
          finished_d = 1'b1;
          state_d    = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Give up on the slave. The client still receives a completion pulse.
          rdata_d    = '0;
          timeout_d  = 1'b1;
          finished_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_REQ: begin
        if (!s1_waitrequest) begin
          finished_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        // Requests are ignored here. This gives the client one cycle to drop them.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    read_n_d  = (state_d != ST_RD_REQ);
    write_n_d = (state_d != ST_WR_REQ);
    cs_d      = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
    be_n_d    = cs_d ? 4'h0 : 4'hF;
    busy_d    = (state_d != ST_IDLE);
  end

  // State and registered-output flops. An asynchronous reset aborts any transfer in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      finished_q <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      read_n_q   <= 1'b1;
      write_n_q  <= 1'b1;
      cs_q       <= 1'b0;
      be_n_q     <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      finished_q <= finished_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      read_n_q   <= read_n_d;
      write_n_q  <= write_n_d;
      cs_q       <= cs_d;
      be_n_q     <= be_n_d;
    end
  end

  assign sdram_readdata                         = rdata_q;
  assign sdram_finished                         = finished_q;
  assign o_busy                                 = busy_q;
  assign o_timeout                              = timeout_q;
  assign o_state                                = state_q;
  assign new_sdram_controller_0_s1_address      = addr_q;
  assign new_sdram_controller_0_s1_byteenable_n = be_n_q;
  assign new_sdram_controller_0_s1_chipselect   = cs_q;
  assign new_sdram_controller_0_s1_writedata    = wdata_q;
  assign new_sdram_controller_0_s1_read_n       = read_n_q;
  assign new_sdram_controller_0_s1_write_n      = write_n_q;

endmodule

// File: tb/tb_sdram_avalon_master.sv
// Bench for sdram_avalon_master. A bench-side SDRAM slave applies random
// waitrequest and readdatavalid timing. The expected results come from a plain
// memory model and the timing rules for each transfer.
module tb_sdram_avalon_master;

  localparam int TO = 16;

  logic        i_clk, i_rst;
  logic        sdram_read, sdram_write;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_writedata, sdram_readdata;
  logic        sdram_finished, o_busy, o_timeout;
  logic [2:0]  o_state;
  logic [22:0] s1_address;
  logic [3:0]  s1_be_n;
  logic        s1_cs, s1_read_n, s1_write_n;
  logic [31:0] s1_wdata, s1_rdata;
  logic        s1_rdv, s1_waitreq;

  sdram_avalon_master #(.ADDR_W(23), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk                                   (i_clk),
    .i_rst                                   (i_rst),
    .sdram_read                              (sdram_read),
    .sdram_write                             (sdram_write),
    .sdram_addr                              (sdram_addr),
    .sdram_writedata                         (sdram_writedata),
    .sdram_readdata                          (sdram_readdata),
    .sdram_finished                          (sdram_finished),
    .o_busy                                  (o_busy),
    .o_timeout                               (o_timeout),
    .o_state                                 (o_state),
    .new_sdram_controller_0_s1_address       (s1_address),
    .new_sdram_controller_0_s1_byteenable_n  (s1_be_n),
    .new_sdram_controller_0_s1_chipselect    (s1_cs),
    .new_sdram_controller_0_s1_writedata     (s1_wdata),
    .new_sdram_controller_0_s1_read_n        (s1_read_n),
    .new_sdram_controller_0_s1_write_n       (s1_write_n),
    .new_sdram_controller_0_s1_readdata      (s1_rdata),
    .new_sdram_controller_0_s1_readdatavalid (s1_rdv),
    .new_sdram_controller_0_s1_waitrequest   (s1_waitreq)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cycle = 0;
  int n_acc = 0;

  // Slave behaviour knobs and state.
  int          sl_nwait = 0;
  int          sl_lat   = 0;
  bit          sl_mute  = 1'b0;
  int          sl_wcnt  = 0;
  int          sl_rdv_cd = -1;
  logic [22:0] sl_rd_addr = '0;
  logic [31:0] slave_mem [logic [22:0]];

  // Reference model: memory contents, last returned read data, sticky timeout.
  logic [31:0] model_mem [logic [22:0]];
  logic [31:0] model_rdata = '0;
  bit          model_to = 1'b0;
  logic [22:0] pool [8];

  // One slave cycle, called at each negedge once the DUT outputs have settled.
  task automatic slave_cycle();
    s1_rdv   = 1'b0;
    s1_rdata = $urandom;
    if (!s1_write_n || !s1_read_n) begin
      s1_waitreq = (sl_wcnt < sl_nwait);
      sl_wcnt++;
      if (!s1_waitreq) begin
        sl_wcnt   = 0;
        acc_cycle = cyc;
        n_acc++;
        if (!s1_write_n) slave_mem[s1_address] = s1_wdata;
        else if (!sl_mute) begin
          sl_rdv_cd  = sl_lat;
          sl_rd_addr = s1_address;
        end
      end
    end else begin
      s1_waitreq = 1'($urandom_range(0, 1));
      sl_wcnt    = 0;
      // A stray readdatavalid while idle must be ignored.
      if (!o_busy && sl_rdv_cd < 0) s1_rdv = 1'($urandom_range(0, 1));
    end
    if (sl_rdv_cd == 0) begin
      s1_rdv    = 1'b1;
      s1_rdata  = slave_mem.exists(sl_rd_addr) ? slave_mem[sl_rd_addr] : 32'h0;
      sl_rdv_cd = -1;
    end else if (sl_rdv_cd > 0) begin
      sl_rdv_cd--;
    end
  endtask

  // One complete transfer plus one idle cycle after it, checked against the model.
  task automatic xfer(input bit do_rd, input bit do_wr, input logic [22:0] a,
                      input logic [31:0] d, input int nwait, input int lat,
                      input bit mute, input string name);
    int          wn_low = 0, rn_low = 0, strobe_bad = 0, busy_bad = 0;
    int          fin_cnt = 0, fin_cyc = 0, acc0, exp_gap;
    logic [31:0] fin_data = '0, exp_data;
    logic [2:0]  fin_state = '0;
    bit          is_rd = do_rd;
    sl_nwait = nwait; sl_lat = lat; sl_mute = mute;
    acc0 = n_acc;
    if (is_rd) begin
      exp_data = mute ? 32'h0 : model_mem[a];
      exp_gap  = (mute ? TO : lat) + 1;
    end else begin
      exp_data = model_rdata;
      exp_gap  = 1;
    end
    @(negedge i_clk); cyc++;
    sdram_read = do_rd; sdram_write = do_wr; sdram_addr = a; sdram_writedata = d;
    slave_cycle();
    for (int i = 0; i < 200 && fin_cnt == 0; i++) begin
      @(negedge i_clk); cyc++;
      // The client drops its request and scrambles addr/data. The DUT must use the latched values.
      sdram_read = 1'b0; sdram_write = 1'b0;
      sdram_addr = 23'($urandom); sdram_writedata = $urandom;
      slave_cycle();
      if (!s1_write_n) wn_low++;
      if (!s1_read_n) rn_low++;
      if ((!s1_write_n || !s1_read_n) &&
          (s1_address !== a || s1_be_n !== 4'h0 || s1_cs !== 1'b1 ||
           o_state !== (is_rd ? 3'd1 : 3'd3) || (!s1_write_n && s1_wdata !== d)))
        strobe_bad++;
      if (s1_write_n && s1_read_n && (s1_cs !== 1'b0 || s1_be_n !== 4'hF)) strobe_bad++;
      if (o_busy !== 1'b1) busy_bad++;
      if (sdram_finished === 1'b1) begin
        fin_cnt++; fin_cyc = cyc; fin_data = sdram_readdata; fin_state = o_state;
      end
    end
    total++;
    if (fin_cnt != 1) begin
      bad++; $display("FAIL %s finished_seen: got %0d want 1 (cycle budget)", name, fin_cnt);
      return;
    end
    total++;
    if (n_acc - acc0 != 1) begin bad++; $display("FAIL %s accepts: got %0d want 1", name, n_acc - acc0); end
    total++;
    if (wn_low != (is_rd ? 0 : nwait + 1)) begin
      bad++; $display("FAIL %s write_n_low_cycles: got %0d want %0d", name, wn_low, is_rd ? 0 : nwait + 1);
    end
    total++;
    if (rn_low != (is_rd ? nwait + 1 : 0)) begin
      bad++; $display("FAIL %s read_n_low_cycles: got %0d want %0d", name, rn_low, is_rd ? nwait + 1 : 0);
    end
    total++;
    if (strobe_bad != 0) begin bad++; $display("FAIL %s strobe_fields: got %0d bad cycles want 0", name, strobe_bad); end
    total++;
    if (busy_bad != 0) begin bad++; $display("FAIL %s busy: got %0d low cycles want 0", name, busy_bad); end
    total++;
    if (fin_cyc - acc_cycle != exp_gap) begin
      bad++; $display("FAIL %s finish_latency: got %0d want %0d", name, fin_cyc - acc_cycle, exp_gap);
    end
    total++;
    if (fin_state !== 3'd4) begin bad++; $display("FAIL %s done_state: got %0d want 4", name, fin_state); end
    total++;
    if (fin_data !== exp_data) begin bad++; $display("FAIL %s readdata: got %h want %h", name, fin_data, exp_data); end
    if (is_rd) begin
      model_rdata = exp_data;
      if (mute) model_to = 1'b1;
    end else begin
      model_mem[a] = d;
    end
    @(negedge i_clk); cyc++;
    slave_cycle();
    total++;
    if ({sdram_finished, o_busy, o_state} !== 5'b0 || sdram_readdata !== model_rdata) begin
      bad++; $display("FAIL %s after_done: got fin=%b busy=%b st=%0d rd=%h want 0 0 0 %h",
                      name, sdram_finished, o_busy, o_state, sdram_readdata, model_rdata);
    end
    total++;
    if (o_timeout !== model_to) begin bad++; $display("FAIL %s timeout_flag: got %b want %b", name, o_timeout, model_to); end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; sdram_read = 1'b0; sdram_write = 1'b0; sdram_addr = '0; sdram_writedata = '0;
    s1_rdv = 1'b0; s1_waitreq = 1'b1; s1_rdata = '0;
    #1 i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    total++;
    if ({o_state, s1_read_n, s1_write_n, s1_cs, s1_be_n, sdram_finished, o_busy, o_timeout} !== {3'd0, 1'b1, 1'b1, 1'b0, 4'hF, 3'b000}) begin
      bad++; $display("FAIL reset_ctrl: got st=%0d rn=%b wn=%b cs=%b be=%h fin=%b busy=%b to=%b want 0 1 1 0 f 0 0 0",
                      o_state, s1_read_n, s1_write_n, s1_cs, s1_be_n, sdram_finished, o_busy, o_timeout);
    end
    total++;
    if (s1_address !== 23'h0 || s1_wdata !== 32'h0 || sdram_readdata !== 32'h0) begin
      bad++; $display("FAIL reset_data: got addr=%h wd=%h rd=%h want 0 0 0", s1_address, s1_wdata, sdram_readdata);
    end
    i_rst = 1'b1;
  endtask

  task automatic test_write_wait();
    xfer(1'b0, 1'b1, 23'h000010, 32'hDEADBEEF, 3, 0, 1'b0, "write_wait3");
  endtask

  task automatic test_read_directed();
    slave_mem[23'h7FFFFF] = 32'h12345678;
    model_mem[23'h7FFFFF] = 32'h12345678;
    xfer(1'b1, 1'b0, 23'h7FFFFF, 32'h0, 0, 2, 1'b0, "read_lat2");
  endtask

  task automatic test_both_high();
    xfer(1'b1, 1'b1, pool[4], $urandom, 1, 3, 1'b0, "both_high");
  endtask

  task automatic test_zero_latency();
    xfer(1'b1, 1'b0, pool[2], 32'h0, 2, 0, 1'b0, "read_zero_lat");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 9);
      logic [22:0] a = pool[$urandom_range(0, 7)];
      if (k < 4) xfer(1'b0, 1'b1, a, $urandom, $urandom_range(0, 3), 0, 1'b0, "rand_write");
      else if (k < 9) xfer(1'b1, 1'b0, a, 32'h0, $urandom_range(0, 3), $urandom_range(0, 6), 1'b0, "rand_read");
      else xfer(1'b1, 1'b1, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 4), 1'b0, "rand_both");
    end
  endtask

  task automatic test_timeout();
    xfer(1'b1, 1'b0, pool[3], 32'h0, 1, 0, 1'b1, "read_timeout");
  endtask

  // The client holds its request through finished, so two transfers run back to back.
  task automatic test_hold(input bit rd);
    logic [22:0] a = pool[5];
    logic [31:0] d = $urandom;
    logic [31:0] exp_data = rd ? model_mem[a] : model_rdata;
    int fin_cnt = 0, f1 = 0, f2 = 0, strobes = 0, exp_gap = rd ? 4 : 3;
    int post_bad = 0;
    sl_nwait = 0; sl_lat = 1; sl_mute = 1'b0;
    @(negedge i_clk); cyc++;
    sdram_read = rd; sdram_write = !rd; sdram_addr = a; sdram_writedata = d;
    slave_cycle();
    for (int i = 0; i < 40 && fin_cnt < 2; i++) begin
      @(negedge i_clk); cyc++;
      slave_cycle();
      if (!s1_write_n || !s1_read_n) strobes++;
      if (sdram_finished === 1'b1) begin
        fin_cnt++;
        if (fin_cnt == 1) f1 = cyc; else f2 = cyc;
        if (fin_cnt == 2) begin sdram_read = 1'b0; sdram_write = 1'b0; end
      end
    end
    if (!rd) model_mem[a] = d;
    else model_rdata = exp_data;
    total++;
    if (fin_cnt != 2) begin bad++; $display("FAIL hold_%0d pulses: got %0d want 2", rd, fin_cnt); end
    total++;
    if (f2 - f1 != exp_gap) begin bad++; $display("FAIL hold_%0d pulse_gap: got %0d want %0d", rd, f2 - f1, exp_gap); end
    total++;
    if (strobes != 2) begin bad++; $display("FAIL hold_%0d strobe_cycles: got %0d want 2", rd, strobes); end
    total++;
    if (sdram_readdata !== model_rdata) begin bad++; $display("FAIL hold_%0d readdata: got %h want %h", rd, sdram_readdata, model_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk); cyc++;
      slave_cycle();
      if (sdram_finished !== 1'b0 || o_state !== 3'd0) post_bad++;
    end
    total++;
    if (post_bad != 0) begin bad++; $display("FAIL hold_%0d idle_after: got %0d bad cycles want 0", rd, post_bad); end
    total++;
    if (o_timeout !== model_to) begin bad++; $display("FAIL hold_%0d timeout_flag: got %b want %b", rd, o_timeout, model_to); end
  endtask

  task automatic test_reset_midread();
    int reached = 0, post_bad = 0;
    sl_nwait = 1; sl_lat = 0; sl_mute = 1'b1;
    @(negedge i_clk); cyc++;
    sdram_read = 1'b1; sdram_addr = pool[6];
    slave_cycle();
    for (int i = 0; i < 20 && reached == 0; i++) begin
      @(negedge i_clk); cyc++;
      sdram_read = 1'b0;
      slave_cycle();
      if (o_state === 3'd2) reached = 1;
    end
    total++;
    if (reached == 0) begin bad++; $display("FAIL midread_reach_wait: got 0 want 1 (cycle budget)"); end
    @(negedge i_clk); cyc++;
    i_rst = 1'b0;
    #1;
    model_rdata = '0; model_to = 1'b0;
    total++;
    if ({o_state, s1_read_n, s1_write_n, s1_cs, s1_be_n, sdram_finished, o_busy, o_timeout} !== {3'd0, 1'b1, 1'b1, 1'b0, 4'hF, 3'b000}) begin
      bad++; $display("FAIL midread_reset_ctrl: got st=%0d rn=%b wn=%b cs=%b be=%h fin=%b busy=%b to=%b want 0 1 1 0 f 0 0 0",
                      o_state, s1_read_n, s1_write_n, s1_cs, s1_be_n, sdram_finished, o_busy, o_timeout);
    end
    total++;
    if (s1_address !== 23'h0 || s1_wdata !== 32'h0 || sdram_readdata !== 32'h0) begin
      bad++; $display("FAIL midread_reset_data: got addr=%h wd=%h rd=%h want 0 0 0", s1_address, s1_wdata, sdram_readdata);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    s1_rdv = 1'b1; s1_rdata = $urandom; s1_waitreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      s1_rdv = 1'b0;
      if (sdram_finished !== 1'b0 || o_state !== 3'd0 || o_busy !== 1'b0) post_bad++;
    end
    total++;
    if (post_bad != 0 || sdram_readdata !== 32'h0) begin
      bad++; $display("FAIL midread_late_valid: got %0d bad cycles rd=%h want 0 and 0", post_bad, sdram_readdata);
    end
  endtask

  initial begin
    pool[0] = 23'h000000;
    pool[1] = 23'h7FFFFF;
    pool[2] = 23'h000010;
    for (int i = 3; i < 8; i++) pool[i] = 23'($urandom);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] v = $urandom;
      slave_mem[pool[i]] = v;
      model_mem[pool[i]] = v;
    end
    test_reset();
    test_write_wait();
    test_read_directed();
    test_both_high();
    test_zero_latency();
    test_random();
    test_timeout();
    test_hold(1'b0);
    test_hold(1'b1);
    test_reset_midread();
    xfer(1'b0, 1'b1, pool[7], $urandom, 1, 0, 1'b0, "after_reset_write");
    xfer(1'b1, 1'b0, pool[7], 32'h0, 0, 1, 1'b0, "after_reset_read");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired want finished");
    $fatal(1, "time limit");
  end

endmodule
